// File: rtl/spread_pkg.sv
// ---------------------------------------------------------------------------
// spread_pkg
// Shared constants and helpers for the windowed spread statistics block.
//   PRICE_W_DEFAULT     default width of unsigned buy/sell prices
//   LOG2_DEPTH_DEFAULT  default log2 of the moving-average window
//   SPREAD_W_DEFAULT    signed spread width (one extra bit for buy - sell)
//   SUM_W_DEFAULT       running window sum width (spread + log2 depth)
//   CNT_W / CNT_MAX     width and saturation value of the match counter
//   sat_inc()           saturating increment for the match counter
// ---------------------------------------------------------------------------
package spread_pkg;

    localparam int PRICE_W_DEFAULT    = 8;
    localparam int LOG2_DEPTH_DEFAULT = 3;
    localparam int SPREAD_W_DEFAULT   = PRICE_W_DEFAULT + 1;
    localparam int SUM_W_DEFAULT      = SPREAD_W_DEFAULT + LOG2_DEPTH_DEFAULT;
    localparam int CNT_W              = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/spread_window.sv
// ---------------------------------------------------------------------------
// spread_window
// Moving-average window over the last DEPTH = 2**LOG2_DEPTH spreads.
// Holds a circular buffer, a saturating fill count and a running sum so
// the average never needs to re-add the whole window.
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, zeroes buffer and state
//   clear      in   synchronous clear of count/sum/pointer (wins over push)
//   push       in   write din into the window this cycle
//   din        in   signed spread sample
//   avg        out  floor(sum / DEPTH), zero until the window is full
//   avg_valid  out  window holds DEPTH samples
// ---------------------------------------------------------------------------
module spread_window
    import spread_pkg::*;
#(
    parameter int SPREAD_W   = SPREAD_W_DEFAULT,
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic signed [SPREAD_W-1:0] din,
    output logic signed [SPREAD_W-1:0] avg,
    output logic                       avg_valid
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = SPREAD_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] DEPTH_CNT = (LOG2_DEPTH + 1)'(DEPTH);

    logic signed [SPREAD_W-1:0] buf_q [DEPTH];
    logic signed [SPREAD_W-1:0] buf_d [DEPTH];
    logic [LOG2_DEPTH-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH:0]        count_q, count_d;
    logic signed [SUM_W-1:0]    sum_q, sum_d;
    logic signed [SUM_W-1:0]    din_ext;
    logic signed [SUM_W-1:0]    evict_ext;
    logic                       full;

    assign full = (count_q == DEPTH_CNT);

    // Once the window is full the slot about to be overwritten is the
    // oldest sample, so its value leaves the running sum as din enters.
    always_comb begin
        buf_d     = buf_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        sum_d     = sum_q;
        din_ext   = SUM_W'(din);
        evict_ext = full ? SUM_W'(buf_q[wr_ptr_q]) : '0;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
            sum_d    = '0;
        end else if (push) begin
            buf_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            count_d         = full ? count_q : count_q + 1'b1;
            sum_d           = sum_q + din_ext - evict_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            count_q  <= '0;
            sum_q    <= '0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
        end
    end

    // Dropping the low LOG2_DEPTH bits of the signed sum is an arithmetic
    // shift, so the average rounds toward minus infinity.
    assign avg_valid = full;
    assign avg       = full ? $signed(sum_q[SUM_W-1:LOG2_DEPTH]) : '0;

endmodule

// File: rtl/spread_window_stats.sv
// ---------------------------------------------------------------------------
// spread_window_stats
// Registers the signed spread (buy - sell) of every accepted match and keeps
// lifetime min/max, a DEPTH-sample moving average, a crossed-book flag and a
// saturating match counter.
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   match_signal  in   one-cycle strobe per match
//   enable_count  in   qualifies match_signal
//   clear_stats   in   synchronous clear of statistics (spread/crossed hold)
//   buy_price     in   unsigned buy price, sampled on accept
//   sell_price    in   unsigned sell price, sampled on accept
//   spread        out  last accepted spread (signed)
//   spread_valid  out  pulse the cycle after an accept
//   crossed       out  last accepted spread is negative
//   spread_min    out  minimum spread since reset/clear
//   spread_max    out  maximum spread since reset/clear
//   spread_avg    out  floor of window average, 0 until window full
//   stats_valid   out  at least one accept since reset/clear
//   avg_valid     out  window holds DEPTH samples
//   match_total   out  accepted matches since reset/clear, saturating
// ---------------------------------------------------------------------------
module spread_window_stats
    import spread_pkg::*;
#(
    parameter int PRICE_W    = PRICE_W_DEFAULT,
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      match_signal,
    input  logic                      enable_count,
    input  logic                      clear_stats,
    input  logic [PRICE_W-1:0]        buy_price,
    input  logic [PRICE_W-1:0]        sell_price,
    output logic signed [PRICE_W:0]   spread,
    output logic                      spread_valid,
    output logic                      crossed,
    output logic signed [PRICE_W:0]   spread_min,
    output logic signed [PRICE_W:0]   spread_max,
    output logic signed [PRICE_W:0]   spread_avg,
    output logic                      stats_valid,
    output logic                      avg_valid,
    output logic [CNT_W-1:0]          match_total
);

    localparam int SPREAD_W = PRICE_W + 1;

    logic                       accept;
    logic signed [SPREAD_W-1:0] diff;

    logic signed [SPREAD_W-1:0] spread_q, spread_d;
    logic                       spread_valid_q, spread_valid_d;
    logic signed [SPREAD_W-1:0] min_q, min_d;
    logic signed [SPREAD_W-1:0] max_q, max_d;
    logic                       stats_valid_q, stats_valid_d;
    logic [CNT_W-1:0]           total_q, total_d;

    // A clear in the same cycle as a match drops that match entirely.
    assign accept = match_signal & enable_count & ~clear_stats;

    // Zero-extending both prices first makes the subtraction exact.
    assign diff = $signed({1'b0, buy_price}) - $signed({1'b0, sell_price});

    // The first accept after reset/clear seeds both extremes so the zero
    // held while stats are invalid never leaks into the comparison.
    always_comb begin
        spread_d       = spread_q;
        spread_valid_d = 1'b0;
        min_d          = min_q;
        max_d          = max_q;
        stats_valid_d  = stats_valid_q;
        total_d        = total_q;
        if (clear_stats) begin
            min_d         = '0;
            max_d         = '0;
            stats_valid_d = 1'b0;
            total_d       = '0;
        end else if (accept) begin
            spread_d       = diff;
            spread_valid_d = 1'b1;
            stats_valid_d  = 1'b1;
            total_d        = sat_inc(total_q);
            if (!stats_valid_q) begin
                min_d = diff;
                max_d = diff;
            end else begin
                if (diff < min_q) begin
                    min_d = diff;
                end
                if (diff > max_q) begin
                    max_d = diff;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spread_q       <= '0;
            spread_valid_q <= 1'b0;
            min_q          <= '0;
            max_q          <= '0;
            stats_valid_q  <= 1'b0;
            total_q        <= '0;
        end else begin
            spread_q       <= spread_d;
            spread_valid_q <= spread_valid_d;
            min_q          <= min_d;
            max_q          <= max_d;
            stats_valid_q  <= stats_valid_d;
            total_q        <= total_d;
        end
    end

    spread_window #(
        .SPREAD_W   (SPREAD_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_window (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_stats),
        .push      (accept),
        .din       (diff),
        .avg       (spread_avg),
        .avg_valid (avg_valid)
    );

    assign spread       = spread_q;
    assign spread_valid = spread_valid_q;
    assign crossed      = spread_q[SPREAD_W-1];
    assign spread_min   = min_q;
    assign spread_max   = max_q;
    assign stats_valid  = stats_valid_q;
    assign match_total  = total_q;

endmodule

// File: tb/tb_spread_window_stats.sv
// ---------------------------------------------------------------------------
// tb_spread_window_stats
// Table-driven bench for spread_window_stats (PRICE_W=8, DEPTH=8). Each
// record holds the inputs for one clock and the outputs expected after it.
// ---------------------------------------------------------------------------
module tb_spread_window_stats;

    typedef struct {
        string             name;
        logic              rst;
        logic              match;
        logic              en;
        logic              clr;
        logic [7:0]        buy;
        logic [7:0]        sell;
        logic signed [8:0] sp;
        logic              sp_valid;
        logic              cr;
        logic signed [8:0] mn;
        logic signed [8:0] mx;
        logic signed [8:0] av;
        logic              st_valid;
        logic              av_valid;
        logic [15:0]       tot;
    } vec_t;

    logic              clk;
    logic              reset;
    logic              match_signal;
    logic              enable_count;
    logic              clear_stats;
    logic [7:0]        buy_price;
    logic [7:0]        sell_price;
    logic signed [8:0] spread;
    logic              spread_valid;
    logic              crossed;
    logic signed [8:0] spread_min;
    logic signed [8:0] spread_max;
    logic signed [8:0] spread_avg;
    logic              stats_valid;
    logic              avg_valid;
    logic [15:0]       match_total;

    int   checks_total;
    int   checks_passed;
    vec_t vecs[$];

    spread_window_stats #(
        .PRICE_W    (8),
        .LOG2_DEPTH (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .match_signal (match_signal),
        .enable_count (enable_count),
        .clear_stats  (clear_stats),
        .buy_price    (buy_price),
        .sell_price   (sell_price),
        .spread       (spread),
        .spread_valid (spread_valid),
        .crossed      (crossed),
        .spread_min   (spread_min),
        .spread_max   (spread_max),
        .spread_avg   (spread_avg),
        .stats_valid  (stats_valid),
        .avg_valid    (avg_valid),
        .match_total  (match_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input string nm, input logic rst, input logic m, input logic e,
                          input logic c, input int buy, input int sell, input int sp,
                          input logic spv, input logic cr, input int mn, input int mx,
                          input int av, input logic stv, input logic avv, input int tot);
        vec_t v;
        v.name     = nm;
        v.rst      = rst;
        v.match    = m;
        v.en       = e;
        v.clr      = c;
        v.buy      = 8'(buy);
        v.sell     = 8'(sell);
        v.sp       = 9'(sp);
        v.sp_valid = spv;
        v.cr       = cr;
        v.mn       = 9'(mn);
        v.mx       = 9'(mx);
        v.av       = 9'(av);
        v.st_valid = stv;
        v.av_valid = avv;
        v.tot      = 16'(tot);
        vecs.push_back(v);
    endtask

    task automatic checkField(input string nm, input string fld, input int act, input int exp);
        checks_total++;
        if (act == exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset        = v.rst;
        match_signal = v.match;
        enable_count = v.en;
        clear_stats  = v.clr;
        buy_price    = v.buy;
        sell_price   = v.sell;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        checkField(v.name, "spread",       int'(spread),       int'(v.sp));
        checkField(v.name, "spread_valid", int'(spread_valid), int'(v.sp_valid));
        checkField(v.name, "crossed",      int'(crossed),      int'(v.cr));
        checkField(v.name, "spread_min",   int'(spread_min),   int'(v.mn));
        checkField(v.name, "spread_max",   int'(spread_max),   int'(v.mx));
        checkField(v.name, "spread_avg",   int'(spread_avg),   int'(v.av));
        checkField(v.name, "stats_valid",  int'(stats_valid),  int'(v.st_valid));
        checkField(v.name, "avg_valid",    int'(avg_valid),    int'(v.av_valid));
        checkField(v.name, "match_total",  int'(match_total),  int'(v.tot));
    endtask

    initial begin
        vec_t zero_v;
        checks_total  = 0;
        checks_passed = 0;

        // Basic accept, negative spread, gated match, idle hold.
        addVec("acc_pos", 0, 1, 1, 0, 100,  90,  10, 1, 0,  10, 10, 0, 1, 0, 1);
        addVec("acc_neg", 0, 1, 1, 0,  50,  70, -20, 1, 1, -20, 10, 0, 1, 0, 2);
        addVec("gated",   0, 1, 0, 0,   1,   2, -20, 0, 1, -20, 10, 0, 1, 0, 2);
        addVec("idle",    0, 0, 0, 0,   0,   0, -20, 0, 1, -20, 10, 0, 1, 0, 2);
        // Clear with a simultaneous accept: match dropped, spread holds.
        addVec("clr_acc", 0, 1, 1, 1,   5,   1, -20, 0, 1,   0,  0, 0, 0, 0, 0);
        // Spreads 1..8 fill the window: sum 36, avg 4.
        for (int k = 1; k <= 8; k++) begin
            addVec("win_fill", 0, 1, 1, 0, 10 + k, 10, k, 1, 0, 1, k,
                   (k == 8) ? 4 : 0, 1, logic'(k == 8), k);
        end
        // 17 evicts 1: sum 52, avg 6.
        addVec("win_slide", 0, 1, 1, 0, 27, 10, 17, 1, 0, 1, 17, 6, 1, 1, 9);
        addVec("clr",       0, 0, 0, 1,  0,  0, 17, 0, 0, 0,  0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            addVec("neg_fill", 0, 1, 1, 0, 10, 13, -3, 1, 1, -3, -3,
                   (k == 8) ? -3 : 0, 1, logic'(k == 8), k);
        end
        // -4 evicts a -3: sum -25, floor(-25/8) = -4.
        addVec("neg_floor", 0, 1, 1, 0, 10, 14, -4, 1, 1, -4, -3, -4, 1, 1, 9);
        for (int k = 1; k <= 7; k++) begin
            addVec("neg_hold", 0, 1, 1, 0, 10, 13, -3, 1, 1, -4, -3, -4, 1, 1, 9 + k);
        end
        // Full-scale spreads in both directions, back to back.
        addVec("clr_acc2", 0, 1, 1, 1, 255,   0,   -3, 0, 1,    0,   0, 0, 0, 0, 0);
        addVec("max_pos",  0, 1, 1, 0, 255,   0,  255, 1, 0,  255, 255, 0, 1, 0, 1);
        addVec("max_neg",  0, 1, 1, 0,   0, 255, -255, 1, 1, -255, 255, 0, 1, 0, 2);
        addVec("pre_rst",  0, 1, 1, 0,  15,  10,    5, 1, 0, -255, 255, 0, 1, 0, 3);
        addVec("pre_rst",  0, 1, 1, 0,  15,  10,    5, 1, 0, -255, 255, 0, 1, 0, 4);
        // Reset beats accept and discards the partial window.
        addVec("rst_acc",  1, 1, 1, 0,  15,  10,    0, 0, 0,    0,   0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            addVec("post_rst", 0, 1, 1, 0, 12, 10, 2, 1, 0, 2, 2,
                   (k == 8) ? 2 : 0, 1, logic'(k == 8), k);
        end
        addVec("hold", 0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 2, 2, 1, 1, 8);

        // Reset, then ten idle cycles: everything reads zero.
        reset        = 1'b1;
        match_signal = 1'b0;
        enable_count = 1'b0;
        clear_stats  = 1'b0;
        buy_price    = '0;
        sell_price   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        zero_v = '{name: "reset_idle", rst: 0, match: 0, en: 0, clr: 0, buy: 0, sell: 0,
                   sp: 0, sp_valid: 0, cr: 0, mn: 0, mx: 0, av: 0, st_valid: 0,
                   av_valid: 0, tot: 0};
        checkOutput(zero_v);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
